// File: rtl/csr_timer_compare_pkg.sv
// Shared definitions for the CSR timer compare block: CSR address defaults,
// control bit positions, compare reset value and the comparator stage record.
package csr_timer_compare_pkg;

  localparam logic [11:0] DEFAULT_ADDRESS_LOWER   = 12'h000;
  localparam logic [11:0] DEFAULT_ADDRESS_UPPER   = 12'h000;
  localparam logic [11:0] DEFAULT_ADDRESS_CONTROL = 12'h000;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_PENDING_BIT = 1;

  localparam logic [63:0] COMPARE_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Registered partial results of the split 64-bit compare.
  typedef struct packed {
    logic valid;
    logic hi_gt;
    logic hi_eq;
    logic lo_ge;
  } stage_t;

  function automatic logic stage_match(input stage_t s);
    return s.valid && (s.hi_gt || (s.hi_eq && s.lo_ge));
  endfunction

endpackage

// File: rtl/csr_timer_compare_pipe.sv
// Two-stage unsigned 64-bit "value >= compare" check; the halves are compared
// and registered first, then combined. A flush drops the in-flight result.
module csr_timer_compare_pipe
  import csr_timer_compare_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [63:0] value,
  input  logic [63:0] compare,
  output logic        match
);

  stage_t stage;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage <= '0;
    end else begin
      stage.valid <= !flush;
      stage.hi_gt <= value[63:32] >  compare[63:32];
      stage.hi_eq <= value[63:32] == compare[63:32];
      stage.lo_ge <= value[31:0]  >= compare[31:0];
    end
  end

  assign match = stage_match(stage);

endmodule

// File: rtl/csr_timer_compare.sv
// CSR-mapped 64-bit timer compare with sticky pending flag and enable-gated
// interrupt output for the core interrupt controller.
module csr_timer_compare
  import csr_timer_compare_pkg::*;
#(
  parameter logic [11:0] ADDRESS_LOWER   = DEFAULT_ADDRESS_LOWER,
  parameter logic [11:0] ADDRESS_UPPER   = DEFAULT_ADDRESS_UPPER,
  parameter logic [11:0] ADDRESS_CONTROL = DEFAULT_ADDRESS_CONTROL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csrWriteEnable,
  input  logic [11:0] csrWriteAddress,
  input  logic [31:0] csrWriteData,
  input  logic        csrReadEnable,
  input  logic [11:0] csrReadAddress,
  output logic [31:0] csrReadData,
  output logic        csrRequestOutput,
  input  logic [63:0] timerValue,
  output logic        timerInterrupt
);

  logic [63:0] compare_q;
  logic        enable_q;
  logic        pending_q;

  logic write_lower;
  logic write_upper;
  logic write_control;
  logic compare_write;
  logic match;

  assign write_lower   = csrWriteEnable && (csrWriteAddress == ADDRESS_LOWER);
  assign write_upper   = csrWriteEnable && (csrWriteAddress == ADDRESS_UPPER);
  assign write_control = csrWriteEnable && (csrWriteAddress == ADDRESS_CONTROL);
  assign compare_write = write_lower || write_upper;

  csr_timer_compare_pipe u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (compare_write),
    .value   (timerValue),
    .compare (compare_q),
    .match   (match)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      compare_q <= COMPARE_RESET;
      enable_q  <= 1'b0;
    end else begin
      if (write_lower) compare_q[31:0]  <= csrWriteData;
      if (write_upper) compare_q[63:32] <= csrWriteData;
      if (write_control) enable_q <= csrWriteData[CTRL_ENABLE_BIT];
    end
  end

  // A match re-asserts over a W1C clear; a compare write beats both so stale
  // results from the old compare can never set the flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= 1'b0;
    end else if (compare_write) begin
      pending_q <= 1'b0;
    end else if (match) begin
      pending_q <= 1'b1;
    end else if (write_control && csrWriteData[CTRL_PENDING_BIT]) begin
      pending_q <= 1'b0;
    end
  end

  assign timerInterrupt = pending_q && enable_q;

  always_comb begin
    csrReadData      = 32'b0;
    csrRequestOutput = 1'b0;
    if (csrReadEnable) begin
      if (csrReadAddress == ADDRESS_LOWER) begin
        csrReadData      = compare_q[31:0];
        csrRequestOutput = 1'b1;
      end else if (csrReadAddress == ADDRESS_UPPER) begin
        csrReadData      = compare_q[63:32];
        csrRequestOutput = 1'b1;
      end else if (csrReadAddress == ADDRESS_CONTROL) begin
        csrReadData                   = 32'b0;
        csrReadData[CTRL_ENABLE_BIT]  = enable_q;
        csrReadData[CTRL_PENDING_BIT] = pending_q;
        csrRequestOutput              = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_timer_compare.sv
// Directed bench for csr_timer_compare: a vector table for the main flow plus
// hand-written sequences for flush, masking, wrap, decode and mid-run reset.
module tb_csr_timer_compare;

  localparam logic [11:0] A_L = 12'h7D0;
  localparam logic [11:0] A_U = 12'h7D1;
  localparam logic [11:0] A_C = 12'h7D2;

  logic        clk = 1'b0;
  logic        rst;
  logic        csrWriteEnable;
  logic [11:0] csrWriteAddress;
  logic [31:0] csrWriteData;
  logic        csrReadEnable;
  logic [11:0] csrReadAddress;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;
  logic [63:0] timerValue;
  logic        timerInterrupt;

  int checks = 0;
  int errors = 0;

  csr_timer_compare #(
    .ADDRESS_LOWER   (A_L),
    .ADDRESS_UPPER   (A_U),
    .ADDRESS_CONTROL (A_C)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .csrWriteEnable   (csrWriteEnable),
    .csrWriteAddress  (csrWriteAddress),
    .csrWriteData     (csrWriteData),
    .csrReadEnable    (csrReadEnable),
    .csrReadAddress   (csrReadAddress),
    .csrReadData      (csrReadData),
    .csrRequestOutput (csrRequestOutput),
    .timerValue       (timerValue),
    .timerInterrupt   (timerInterrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [63:0] value;
    logic [31:0] exp_rd;
    logic        exp_req;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    csrWriteEnable  = v.we;
    csrWriteAddress = v.waddr;
    csrWriteData    = v.wdata;
    csrReadEnable   = 1'b1;
    csrReadAddress  = v.raddr;
    timerValue      = v.value;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data);
    csrWriteEnable  = 1'b1;
    csrWriteAddress = addr;
    csrWriteData    = data;
    tick();
    csrWriteEnable  = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [11:0] addr,
                            input logic [31:0] exp_rd, input logic exp_irq);
    csrReadEnable  = 1'b1;
    csrReadAddress = addr;
    #1;
    check_output({name, "_rd"}, 64'(csrReadData), 64'(exp_rd));
    check_output({name, "_req"}, 64'(csrRequestOutput), 64'd1);
    check_output({name, "_irq"}, 64'(timerInterrupt), 64'(exp_irq));
  endtask

  initial begin
    // Fields: we, waddr, wdata, raddr, value, exp_rd, exp_req, exp_irq
    vecs[0]  = '{1'b0, A_L, 32'd0,        A_L, 64'd0,            32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, A_L, 32'd0,        A_U, 64'd0,            32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, A_L, 32'd0,        A_C, 64'd0,            32'd0,         1'b1, 1'b0};
    vecs[3]  = '{1'b1, A_C, 32'd1,        A_C, 64'd0,            32'd0,         1'b1, 1'b0};
    vecs[4]  = '{1'b1, A_L, 32'd100,      A_C, 64'd0,            32'd1,         1'b1, 1'b0};
    vecs[5]  = '{1'b1, A_U, 32'd0,        A_L, 64'd98,           32'd100,       1'b1, 1'b0};
    vecs[6]  = '{1'b0, A_L, 32'd0,        A_U, 64'd98,           32'd0,         1'b1, 1'b0};
    vecs[7]  = '{1'b0, A_L, 32'd0,        A_C, 64'd99,           32'd1,         1'b1, 1'b0};
    vecs[8]  = '{1'b0, A_L, 32'd0,        A_C, 64'd100,          32'd1,         1'b1, 1'b0};
    vecs[9]  = '{1'b0, A_L, 32'd0,        A_C, 64'd100,          32'd1,         1'b1, 1'b0};
    vecs[10] = '{1'b0, A_L, 32'd0,        A_C, 64'd100,          32'd3,         1'b1, 1'b1};
    vecs[11] = '{1'b1, A_L, 32'd0,        A_C, 64'h0_FFFF_FFFF,  32'd3,         1'b1, 1'b1};
    vecs[12] = '{1'b1, A_U, 32'd1,        A_C, 64'h0_FFFF_FFFF,  32'd1,         1'b1, 1'b0};
    vecs[13] = '{1'b0, A_L, 32'd0,        A_U, 64'h0_FFFF_FFFF,  32'd1,         1'b1, 1'b0};
    vecs[14] = '{1'b0, A_L, 32'd0,        A_L, 64'h0_FFFF_FFFF,  32'd0,         1'b1, 1'b0};
    vecs[15] = '{1'b0, A_L, 32'd0,        A_C, 64'h1_0000_0000,  32'd1,         1'b1, 1'b0};
    vecs[16] = '{1'b0, A_L, 32'd0,        A_C, 64'h1_0000_0000,  32'd1,         1'b1, 1'b0};
    vecs[17] = '{1'b0, A_L, 32'd0,        A_C, 64'h1_0000_0000,  32'd3,         1'b1, 1'b1};
    vecs[18] = '{1'b1, A_C, 32'd3,        A_C, 64'h1_0000_0000,  32'd3,         1'b1, 1'b1};
    vecs[19] = '{1'b1, A_L, 32'hFFFF_FFFF, A_C, 64'h1_0000_0000, 32'd3,         1'b1, 1'b1};
    vecs[20] = '{1'b1, A_U, 32'hFFFF_FFFF, A_C, 64'h1_0000_0000, 32'd1,         1'b1, 1'b0};
    vecs[21] = '{1'b1, A_C, 32'd3,        A_U, 64'h1_0000_0000,  32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[22] = '{1'b0, A_L, 32'd0,        A_C, 64'h1_0000_0000,  32'd1,         1'b1, 1'b0};
    vecs[23] = '{1'b0, A_L, 32'd0,        A_C, 64'h1_0000_0000,  32'd1,         1'b1, 1'b0};

    rst             = 1'b0;
    csrWriteEnable  = 1'b0;
    csrWriteAddress = '0;
    csrWriteData    = '0;
    csrReadEnable   = 1'b0;
    csrReadAddress  = '0;
    timerValue      = '0;
    tick();
    tick();
    read_check("reset_lower", A_L, 32'hFFFF_FFFF, 1'b0);
    read_check("reset_upper", A_U, 32'hFFFF_FFFF, 1'b0);
    read_check("reset_control", A_C, 32'd0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_rd", i), 64'(csrReadData), 64'(vecs[i].exp_rd));
      check_output($sformatf("vec%0d_req", i), 64'(csrRequestOutput), 64'(vecs[i].exp_req));
      check_output($sformatf("vec%0d_irq", i), 64'(timerInterrupt), 64'(vecs[i].exp_irq));
      tick();
    end
    csrWriteEnable = 1'b0;

    // Matching compare of 10, then moved to 1000: the stale in-flight match must not land.
    timerValue = 64'd500;
    do_write(A_U, 32'd0);
    do_write(A_L, 32'd10);
    tick();
    tick();
    read_check("flush_pre", A_C, 32'd3, 1'b1);
    do_write(A_L, 32'd1000);
    read_check("flush_clear", A_C, 32'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      read_check($sformatf("flush_hold%0d", i), A_C, 32'd1, 1'b0);
    end

    do_write(A_C, 32'd0);
    do_write(A_L, 32'd10);
    tick();
    tick();
    read_check("mask", A_C, 32'd2, 1'b0);

    timerValue = 64'd0;
    tick();
    tick();
    read_check("wrap_sticky", A_C, 32'd2, 1'b0);

    do_write(A_C, 32'd3);
    read_check("w1c_clear", A_C, 32'd1, 1'b0);
    tick();
    tick();
    read_check("w1c_hold", A_C, 32'd1, 1'b0);

    csrReadEnable  = 1'b1;
    csrReadAddress = 12'h123;
    #1;
    check_output("unmapped_rd", 64'(csrReadData), 64'd0);
    check_output("unmapped_req", 64'(csrRequestOutput), 64'd0);
    csrReadEnable  = 1'b0;
    csrReadAddress = A_L;
    #1;
    check_output("noread_rd", 64'(csrReadData), 64'd0);
    check_output("noread_req", 64'(csrRequestOutput), 64'd0);

    timerValue = 64'd500;
    tick();
    tick();
    read_check("prereset", A_C, 32'd3, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    read_check("midreset_control", A_C, 32'd0, 1'b0);
    read_check("midreset_lower", A_L, 32'hFFFF_FFFF, 1'b0);
    read_check("midreset_upper", A_U, 32'hFFFF_FFFF, 1'b0);
    tick();
    tick();
    read_check("postreset_control", A_C, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
